// File: rtl/dma_bus_if.sv
// Memory/peripheral port seen by the copy engine: arbiter handshake plus the
// single-ported Address/Write_data/Read_data bus with MemRead/MemWrite strobes.
`timescale 1ns/1ps
interface dma_bus_if;
  logic        bus_req;
  logic        bus_grant;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;

  modport master (
    output bus_req,
    output mem_addr,
    output mem_wdata,
    output mem_read,
    output mem_write,
    input  bus_grant,
    input  mem_rdata
  );

  modport slave (
    input  bus_req,
    input  mem_addr,
    input  mem_wdata,
    input  mem_read,
    input  mem_write,
    output bus_grant,
    output mem_rdata
  );
endinterface

// File: rtl/dma_copy_master.sv
// Word-by-word block copy engine: one RD cycle then one WR cycle per word, with
// the read data forwarded combinationally onto the write bus during WR.
`timescale 1ns/1ps
module dma_copy_master #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] word_count,
  input  logic             abort,
  dma_bus_if.master        bus,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] remaining
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_WR,
    ST_FIN
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      src_reg, src_next;
  logic [31:0]      dst_reg, dst_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic             aborted_reg, aborted_next;
  logic             abort_pend_reg, abort_pend_next;

  logic             bus_req_int;
  logic [31:0]      mem_addr_int;
  logic [31:0]      mem_wdata_int;
  logic             mem_read_int;
  logic             mem_write_int;
  logic             done_int;
  logic             abort_any;

  // A short abort pulse during RD must still stop the job after that word's WR.
  assign abort_any = abort | abort_pend_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      remaining_reg  <= '0;
      aborted_reg    <= 1'b0;
      abort_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      src_reg        <= src_next;
      dst_reg        <= dst_next;
      remaining_reg  <= remaining_next;
      aborted_reg    <= aborted_next;
      abort_pend_reg <= abort_pend_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    remaining_next  = remaining_reg;
    aborted_next    = aborted_reg;
    abort_pend_next = abort_pend_reg;
    bus_req_int     = 1'b0;
    mem_addr_int    = '0;
    mem_wdata_int   = '0;
    mem_read_int    = 1'b0;
    mem_write_int   = 1'b0;
    done_int        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        abort_pend_next = 1'b0;
        if (start) begin
          src_next       = {src_addr[31:2], 2'b00};
          dst_next       = {dst_addr[31:2], 2'b00};
          remaining_next = word_count;
          aborted_next   = 1'b0;
          state_next     = (word_count == '0) ? ST_FIN : ST_REQ;
        end
      end

      ST_REQ: begin
        bus_req_int     = 1'b1;
        abort_pend_next = abort_pend_reg | abort;
        if (abort_any) begin
          aborted_next = 1'b1;
          state_next   = ST_FIN;
        end else if (bus.bus_grant) begin
          state_next = ST_RD;
        end
      end

      ST_RD: begin
        bus_req_int     = 1'b1;
        mem_addr_int    = src_reg;
        mem_read_int    = 1'b1;
        abort_pend_next = abort_pend_reg | abort;
        state_next      = ST_WR;
      end

      ST_WR: begin
        bus_req_int     = 1'b1;
        mem_addr_int    = dst_reg;
        mem_wdata_int   = bus.mem_rdata;
        mem_write_int   = 1'b1;
        abort_pend_next = abort_pend_reg | abort;
        src_next        = src_reg + 32'd4;
        dst_next        = dst_reg + 32'd4;
        if (remaining_reg != '0) begin
          remaining_next = remaining_reg - LEN_W'(1);
        end
        // Completing the last word wins over a simultaneous abort.
        if (remaining_reg <= LEN_W'(1)) begin
          state_next = ST_FIN;
        end else if (abort_any) begin
          aborted_next = 1'b1;
          state_next   = ST_FIN;
        end else if (!bus.bus_grant) begin
          state_next = ST_REQ;
        end else begin
          state_next = ST_RD;
        end
      end

      ST_FIN: begin
        done_int        = 1'b1;
        abort_pend_next = 1'b0;
        state_next      = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.bus_req   = bus_req_int;
  assign bus.mem_addr  = mem_addr_int;
  assign bus.mem_wdata = mem_wdata_int;
  assign bus.mem_read  = mem_read_int;
  assign bus.mem_write = mem_write_int;

  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_int;
  assign aborted   = aborted_reg;
  assign remaining = remaining_reg;

endmodule

// File: tb/tb_dma_copy_master.sv
// Bench for dma_copy_master: a word memory model on the bus, a sequential-copy
// reference memory, and one task per scenario.
`timescale 1ns/1ps
module tb_dma_copy_master;
  localparam int LEN_W = 10;
  localparam int LIMIT = 3000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] word_count;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] remaining;

  dma_bus_if bus ();

  dma_copy_master #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- memory model (1-cycle registered read) ----------------
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        grant_drv;
  logic        init_go;
  logic        pre_we;
  logic [11:0] pre_idx;
  logic [31:0] pre_data;

  assign bus.bus_grant = grant_drv;

  function automatic logic [31:0] pat(int i);
    logic [31:0] x;
    x = 32'(i + 1);
    return (x * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [11:0] widx(logic [31:0] a);
    return a[13:2];
  endfunction

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else begin
      if (pre_we) mem[pre_idx] <= pre_data;
      if (bus.mem_write) mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
    end
    if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[13:2]];
  end

  // ---------------- bus monitor ----------------
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  int done_cnt = 0;
  int req_cnt  = 0;
  int bus_viol = 0;

  always @(negedge clk) begin
    if (bus.mem_read === 1'b1) rd_q.push_back(bus.mem_addr);
    if (bus.mem_write === 1'b1) wr_q.push_back(bus.mem_addr);
    if (done === 1'b1) done_cnt++;
    if (bus.bus_req === 1'b1) req_cnt++;
    if (bus.mem_read !== 1'b1 && bus.mem_write !== 1'b1 &&
        (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0)) bus_viol++;
    if ((bus.mem_read === 1'b1 || bus.mem_write === 1'b1) && bus.bus_req !== 1'b1) bus_viol++;
  end

  // ---------------- reference model ----------------
  // Ascending word-by-word copy; naturally reproduces overlap behaviour.
  task automatic ref_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] sa, da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      ref_mem[widx(da)] = ref_mem[widx(sa)];
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = widx(a); pre_data = v;
    ref_mem[widx(a)] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                         input int n, output int cyc);
    @(negedge clk);
    rd_q.delete();
    wr_q.delete();
    src_addr = s; dst_addr = d; word_count = LEN_W'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    start = 1'b0; abort = 1'b0; grant_drv = 1'b1; pre_we = 1'b0;
    pre_idx = '0; pre_data = '0; src_addr = '0; dst_addr = '0; word_count = '0;
    init_go = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 init_go = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, aborted} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: got busy/done/aborted=%b want 000", {busy, done, aborted});
    end
    total++;
    if (remaining !== '0) begin
      bad++; $display("FAIL reset_remaining: got %0d want 0", remaining);
    end
    total++;
    if ({bus.bus_req, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== 67'd0) begin
      bad++; $display("FAIL reset_bus: req=%b rd=%b wr=%b addr=%h wdata=%h want all 0",
                      bus.bus_req, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_copy();
    logic [31:0] v[4];
    int cyc, nd;
    for (int i = 0; i < 4; i++) begin
      v[i] = $urandom;
      preload(32'h100 + 32'(4 * i), v[i]);
    end
    run_job(32'h100, 32'h200, 4, cyc);
    ref_copy(32'h100, 32'h200, 4);
    total++;
    if (done !== 1'b1 || cyc != 10) begin
      bad++; $display("FAIL basic_latency: done=%b at cycle %0d want done at cycle 10", done, cyc);
    end
    total++;
    if (remaining !== '0 || aborted !== 1'b0) begin
      bad++; $display("FAIL basic_status: remaining=%0d aborted=%b want 0/0", remaining, aborted);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[widx(32'h200 + 32'(4 * i))] !== v[i]) begin
        bad++; $display("FAIL basic_word%0d: got %h want %h", i,
                        mem[widx(32'h200 + 32'(4 * i))], v[i]);
      end
    end
    nd = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nd++;
    total++;
    if (nd != 0) begin
      bad++; $display("FAIL basic_memory: %0d words differ want 0", nd);
    end
  endtask

  task automatic test_zero_len();
    int cyc, req0;
    req0 = req_cnt;
    run_job(32'h100, 32'h280, 0, cyc);
    total++;
    if (done !== 1'b1 || cyc > 2) begin
      bad++; $display("FAIL zero_latency: done=%b at cycle %0d want done within 2", done, cyc);
    end
    @(negedge clk);
    total++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || req_cnt != req0) begin
      bad++; $display("FAIL zero_bus: reads=%0d writes=%0d req_cycles=%0d want 0/0/0",
                      rd_q.size(), wr_q.size(), req_cnt - req0);
    end
    total++;
    if (remaining !== '0 || aborted !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_status: remaining=%0d aborted=%b busy=%b want 0/0/0",
                      remaining, aborted, busy);
    end
  endtask

  task automatic test_grant_stall();
    int cyc, nd;
    bit found;
    fork
      run_job(32'h300, 32'h340, 3, cyc);
      begin
        found = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (bus.mem_write === 1'b1) begin found = 1; break; end
        end
        if (found) begin
          grant_drv = 1'b0;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (bus.bus_req !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
              bad++; $display("FAIL stall_cycle%0d: req=%b rd=%b wr=%b want 1/0/0",
                              k, bus.bus_req, bus.mem_read, bus.mem_write);
            end
          end
        end
        grant_drv = 1'b1;
      end
    join
    ref_copy(32'h300, 32'h340, 3);
    total++;
    if (!found) begin
      bad++; $display("FAIL stall_first_write: got none want a write");
    end
    total++;
    if (done !== 1'b1 || cyc != 13) begin
      bad++; $display("FAIL stall_latency: done=%b at cycle %0d want 13", done, cyc);
    end
    @(negedge clk);
    nd = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nd++;
    total++;
    if (nd != 0 || remaining !== '0) begin
      bad++; $display("FAIL stall_memory: %0d words differ remaining=%0d want 0/0", nd, remaining);
    end
  endtask

  task automatic test_abort();
    int cyc, nd, nrd;
    bit hit;
    fork
      run_job(32'h400, 32'h480, 8, cyc);
      begin
        nrd = 0; hit = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (bus.mem_read === 1'b1) nrd++;
          if (nrd == 3) begin
            hit = 1;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            break;
          end
        end
      end
    join
    ref_copy(32'h400, 32'h480, 3);
    total++;
    if (done !== 1'b1 || aborted !== 1'b1 || cyc != 8 || !hit) begin
      bad++; $display("FAIL abort_end: done=%b aborted=%b cycle=%0d want 1/1/8", done, aborted, cyc);
    end
    total++;
    if (remaining !== 10'd5 || wr_q.size() != 3) begin
      bad++; $display("FAIL abort_count: remaining=%0d writes=%0d want 5/3", remaining, wr_q.size());
    end
    repeat (3) @(negedge clk);
    total++;
    if (aborted !== 1'b1) begin
      bad++; $display("FAIL abort_hold: aborted=%b want 1", aborted);
    end
    nd = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nd++;
    total++;
    if (nd != 0) begin
      bad++; $display("FAIL abort_memory: %0d words differ want 0", nd);
    end
  endtask

  task automatic test_wrap_align();
    int cyc, nd;
    run_job(32'hFFFF_FFF8, 32'h500, 3, cyc);
    ref_copy(32'hFFFF_FFF8, 32'h500, 3);
    total++;
    if (rd_q.size() != 3 || done !== 1'b1) begin
      bad++; $display("FAIL wrap_reads: got %0d reads done=%b want 3/1", rd_q.size(), done);
    end else begin
      total++;
      if (rd_q[0] !== 32'hFFFF_FFF8 || rd_q[2] !== 32'h0000_0000) begin
        bad++; $display("FAIL wrap_addr: first=%h third=%h want fffffff8/00000000", rd_q[0], rd_q[2]);
      end
    end
    total++;
    if (aborted !== 1'b0) begin
      bad++; $display("FAIL wrap_aborted_cleared: got %b want 0", aborted);
    end
    run_job(32'h101, 32'h603, 2, cyc);
    ref_copy(32'h101, 32'h603, 2);
    total++;
    if (rd_q.size() != 2 || wr_q.size() != 2) begin
      bad++; $display("FAIL align_count: reads=%0d writes=%0d want 2/2", rd_q.size(), wr_q.size());
    end else begin
      total++;
      if (rd_q[0] !== 32'h100 || wr_q[0] !== 32'h600) begin
        bad++; $display("FAIL align_addr: rd=%h wr=%h want 00000100/00000600", rd_q[0], wr_q[0]);
      end
    end
    @(negedge clk);
    nd = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nd++;
    total++;
    if (nd != 0) begin
      bad++; $display("FAIL wrap_memory: %0d words differ want 0", nd);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, nd, d0;
    bit found;
    @(negedge clk);
    src_addr = 32'h100; dst_addr = 32'h800; word_count = 10'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      if (bus.mem_write === 1'b1) begin found = 1; break; end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    total++;
    if (!found || {busy, done, aborted, remaining, bus.bus_req, bus.mem_read,
                   bus.mem_write, bus.mem_addr, bus.mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_mid_outputs: found_wr=%b busy=%b rem=%0d req=%b wr=%b addr=%h want all 0",
                      found, busy, remaining, bus.bus_req, bus.mem_write, bus.mem_addr);
    end
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_nodone: done pulses=%0d busy=%b want 0/0", done_cnt - d0, busy);
    end
    run_job(32'h700, 32'h740, 3, cyc);
    ref_copy(32'h700, 32'h740, 3);
    total++;
    if (done !== 1'b1 || cyc != 8 || remaining !== '0 || aborted !== 1'b0) begin
      bad++; $display("FAIL reset_mid_rerun: done=%b cycle=%0d rem=%0d aborted=%b want 1/8/0/0",
                      done, cyc, remaining, aborted);
    end
    @(negedge clk);
    nd = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nd++;
    total++;
    if (nd != 0) begin
      bad++; $display("FAIL reset_mid_memory: %0d words differ want 0", nd);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nd;
    fork
      run_job(32'h900, 32'h980, 4, cyc);
      begin
        repeat (4) @(negedge clk);
        src_addr = 32'hA00; dst_addr = 32'hA80; word_count = 10'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    ref_copy(32'h900, 32'h980, 4);
    total++;
    if (done !== 1'b1 || cyc != 10 || wr_q.size() != 4) begin
      bad++; $display("FAIL b2b_first: done=%b cycle=%0d writes=%0d want 1/10/4", done, cyc, wr_q.size());
    end
    run_job(32'h980, 32'h9C0, 5, cyc);
    ref_copy(32'h980, 32'h9C0, 5);
    total++;
    if (done !== 1'b1 || cyc != 12) begin
      bad++; $display("FAIL b2b_second: done=%b cycle=%0d want 1/12", done, cyc);
    end
    @(negedge clk);
    nd = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nd++;
    total++;
    if (nd != 0) begin
      bad++; $display("FAIL b2b_memory: %0d words differ want 0", nd);
    end
  endtask

  task automatic test_random();
    logic [31:0] s, d;
    int n, cyc, nd, na;
    for (int it = 0; it < 12; it++) begin
      s = 32'h1000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      d = 32'h1000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      n = $urandom_range(1, 12);
      fork
        run_job(s, d, n, cyc);
        begin
          for (int k = 0; k < LIMIT; k++) begin
            grant_drv = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (done === 1'b1) break;
          end
          grant_drv = 1'b1;
        end
      join
      ref_copy(s, d, n);
      na = 0;
      if (rd_q.size() != n || wr_q.size() != n) na = -1;
      else begin
        for (int i = 0; i < n; i++) begin
          if (rd_q[i] !== {s[31:2], 2'b00} + 32'(4 * i)) na++;
          if (wr_q[i] !== {d[31:2], 2'b00} + 32'(4 * i)) na++;
        end
      end
      total++;
      if (done !== 1'b1 || na != 0 || remaining !== '0 || aborted !== 1'b0) begin
        bad++; $display("FAIL random%0d_job: src=%h dst=%h n=%0d done=%b addr_errs=%0d rem=%0d aborted=%b",
                        it, s, d, n, done, na, remaining, aborted);
      end
      @(negedge clk);
      nd = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nd++;
      total++;
      if (nd != 0) begin
        bad++; $display("FAIL random%0d_memory: %0d words differ want 0", it, nd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_len();
    test_grant_stall();
    test_abort();
    test_wrap_align();
    test_reset_mid();
    test_back_to_back();
    test_random();
    total++;
    if (bus_viol != 0) begin
      bad++; $display("FAIL idle_bus: %0d cycles with stray bus values want 0", bus_viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
